lcd_dma_sched: RTL and testbench



---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_frame_wcnt.sv | 48 ++++
 rtl/lcd_dma_sched.sv | 119 +++++++++++
 tb/tb_lcd_dma_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and default sizing for the LCD DMA scheduler.
// The state enum is shared so other blocks can decode the scheduler state.
package lcd_pkg;

    localparam int LCD_FIFO_AW = 4;
    localparam int LCD_HI_WM   = 12;
    localparam int LCD_LO_WM   = 4;
    localparam int LCD_WCNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } lcd_sched_state_t;

endpackage

// File: rtl/lcd_frame_wcnt.sv
// Per-frame word-budget down-counter with a sticky overrun flag.
// Load wins over decrement, so a push in the reload cycle is not counted.
module lcd_frame_wcnt
    import lcd_pkg::*;
#(
    parameter int WCNT_W = LCD_WCNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WCNT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic [WCNT_W-1:0] cnt_o,
    output logic              zero_o,
    output logic              last_o,
    output logic              ovr_o
);

    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic              ovr_q, ovr_d;

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == WCNT_W'(1));
    assign cnt_o  = cnt_q;
    assign ovr_o  = ovr_q;

    always_comb begin
        cnt_d = cnt_q;
        // A push against an empty budget still flags overrun, even while reloading.
        ovr_d = ovr_q | (dec_i & zero_o);
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && !zero_o) begin
            cnt_d = cnt_q - WCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

endmodule

// File: rtl/lcd_dma_sched.sv
// LCD DMA request scheduler: watermark hysteresis on the pixel FIFO plus a
// per-frame word budget, with base reload on each frame pulse.
module lcd_dma_sched
    import lcd_pkg::*;
#(
    parameter int FIFO_AW = LCD_FIFO_AW,
    parameter int HI_WM   = LCD_HI_WM,
    parameter int LO_WM   = LCD_LO_WM,
    parameter int WCNT_W  = LCD_WCNT_W
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               lcd_en_i,
    input  logic               fp_pulse,
    input  logic [31:0]        upbase_i,
    input  logic [WCNT_W-1:0]  frame_words_i,
    input  logic [FIFO_AW:0]   fifo_level,
    input  logic               fifo_push,
    output logic               dma_req_out,
    output logic               base_load,
    output logic [31:0]        frame_base_out,
    output logic               frame_done,
    output logic [WCNT_W-1:0]  words_left,
    output logic               short_err,
    output logic               ovr_err
);

    localparam logic [FIFO_AW:0] HI_LVL = (FIFO_AW+1)'(HI_WM);
    localparam logic [FIFO_AW:0] LO_LVL = (FIFO_AW+1)'(LO_WM);

    lcd_sched_state_t state_q, state_d;
    logic             dma_req_q, base_load_q, frame_done_q, short_q;
    logic             frame_done_d, short_d;
    logic [31:0]      base_q, base_d;

    logic reload, dec, hit_zero, wc_zero, wc_last, in_frame;

    // Everything is frozen while the LCD is disabled, including push accounting.
    assign dec      = lcd_en_i & fifo_push;
    assign reload   = lcd_en_i & ((state_q == ST_IDLE) | fp_pulse);
    assign hit_zero = dec & ~reload & wc_last;
    assign in_frame = (state_q == ST_FILL) | (state_q == ST_HOLD);

    lcd_frame_wcnt #(.WCNT_W(WCNT_W)) u_wcnt (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .load_i     (reload),
        .load_val_i (frame_words_i),
        .dec_i      (dec),
        .cnt_o      (words_left),
        .zero_o     (wc_zero),
        .last_o     (wc_last),
        .ovr_o      (ovr_err)
    );

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        base_d       = reload ? upbase_i : base_q;
        short_d      = short_q | (lcd_en_i & fp_pulse & in_frame & ~wc_zero);

        if (!lcd_en_i) begin
            state_d = ST_IDLE;
        end else if (reload) begin
            if (frame_words_i == '0) begin
                state_d      = ST_DONE;
                frame_done_d = 1'b1;
            end else begin
                state_d = ST_FILL;
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (hit_zero) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else if (fifo_level >= HI_LVL) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Bursts already in flight may drain the budget while held off.
                    if (hit_zero) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                    end else if (fifo_level <= LO_LVL && !wc_zero) begin
                        state_d = ST_FILL;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            dma_req_q    <= 1'b0;
            base_load_q  <= 1'b0;
            frame_done_q <= 1'b0;
            base_q       <= '0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dma_req_q    <= (state_d == ST_FILL);
            base_load_q  <= reload;
            frame_done_q <= frame_done_d;
            base_q       <= base_d;
            short_q      <= short_d;
        end
    end

    assign dma_req_out    = dma_req_q;
    assign base_load      = base_load_q;
    assign frame_done     = frame_done_q;
    assign frame_base_out = base_q;
    assign short_err      = short_q;

endmodule

// File: tb/tb_lcd_dma_sched.sv
// Bench for lcd_dma_sched: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a frame-level model.
module tb_lcd_dma_sched;

    localparam int AW = 4;
    localparam int WW = 16;
    localparam int HI = 12;
    localparam int LO = 4;

    localparam logic [1:0] M_IDLE = 2'd0, M_FILL = 2'd1, M_HOLD = 2'd2, M_DONE = 2'd3;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic          lcd_en_i = 1'b0;
    logic          fp_pulse = 1'b0;
    logic [31:0]   upbase_i = '0;
    logic [WW-1:0] frame_words_i = '0;
    logic [AW:0]   fifo_level = '0;
    logic          fifo_push = 1'b0;

    logic          dma_req_out, base_load, frame_done, short_err, ovr_err;
    logic [31:0]   frame_base_out;
    logic [WW-1:0] words_left;

    lcd_dma_sched #(.FIFO_AW(AW), .HI_WM(HI), .LO_WM(LO), .WCNT_W(WW)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .lcd_en_i       (lcd_en_i),
        .fp_pulse       (fp_pulse),
        .upbase_i       (upbase_i),
        .frame_words_i  (frame_words_i),
        .fifo_level     (fifo_level),
        .fifo_push      (fifo_push),
        .dma_req_out    (dma_req_out),
        .base_load      (base_load),
        .frame_base_out (frame_base_out),
        .frame_done     (frame_done),
        .words_left     (words_left),
        .short_err      (short_err),
        .ovr_err        (ovr_err)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Frame-level model: what the outputs must be after each edge.
    typedef struct packed {
        logic [1:0]    mode;
        logic [31:0]   base;
        logic [WW-1:0] words;
        logic          req;
        logic          bl;
        logic          fd;
        logic          sh;
        logic          ov;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t step(input mdl_t s);
        mdl_t n;
        bit   reload;
        n = s;
        if (HRESET) return '0;
        n.bl = 1'b0;
        n.fd = 1'b0;
        if (!lcd_en_i) begin
            n.mode = M_IDLE;
        end else begin
            reload = (s.mode == M_IDLE) || fp_pulse;
            if (fifo_push && s.words == 0) n.ov = 1'b1;
            if (reload) begin
                if (fp_pulse && (s.mode == M_FILL || s.mode == M_HOLD) && s.words != 0) n.sh = 1'b1;
                n.base  = upbase_i;
                n.words = frame_words_i;
                n.bl    = 1'b1;
                n.mode  = (frame_words_i == 0) ? M_DONE : M_FILL;
                n.fd    = (frame_words_i == 0);
            end else begin
                if (fifo_push && s.words > 0) n.words = s.words - 1;
                if ((s.mode == M_FILL || s.mode == M_HOLD) && s.words != 0 && n.words == 0) begin
                    n.mode = M_DONE;
                    n.fd   = 1'b1;
                end else if (s.mode == M_FILL && fifo_level >= HI) begin
                    n.mode = M_HOLD;
                end else if (s.mode == M_HOLD && fifo_level <= LO && n.words > 0) begin
                    n.mode = M_FILL;
                end
            end
        end
        n.req = (n.mode == M_FILL);
        return n;
    endfunction

    always @(posedge HCLK) m <= step(m);

    always @(negedge HCLK) begin
        if (chk_en) begin
            check("req",   {31'd0, dma_req_out}, {31'd0, m.req});
            check("bload", {31'd0, base_load},   {31'd0, m.bl});
            check("base",  frame_base_out,       m.base);
            check("fdone", {31'd0, frame_done},  {31'd0, m.fd});
            check("words", {16'd0, words_left},  {16'd0, m.words});
            check("short", {31'd0, short_err},   {31'd0, m.sh});
            check("ovr",   {31'd0, ovr_err},     {31'd0, m.ov});
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        HRESET = 1'b1; lcd_en_i = 1'b0; fp_pulse = 1'b0; fifo_push = 1'b0; fifo_level = '0;
        cyc();
        HRESET = 1'b0;
    endtask

    initial begin
        int lvl;
        cyc();
        chk_en = 1'b1;
        check("rst_req",   {31'd0, dma_req_out}, 32'd0);
        check("rst_base",  frame_base_out,       32'd0);
        check("rst_words", {16'd0, words_left},  32'd0);

        // Basic frame
        HRESET = 1'b0; lcd_en_i = 1'b1; upbase_i = 32'h0001_0200; frame_words_i = 16'd8;
        cyc();
        check("basic_bload", {31'd0, base_load}, 32'd1);
        check("basic_base",  frame_base_out,     32'h0001_0200);
        check("basic_req",   {31'd0, dma_req_out}, 32'd1);
        check("basic_w8",    {16'd0, words_left},  32'd8);
        fifo_push = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("basic_w0",   {16'd0, words_left},  32'd0);
        check("basic_fd",   {31'd0, frame_done},  32'd1);
        check("basic_req0", {31'd0, dma_req_out}, 32'd0);
        fifo_push = 1'b0;
        cyc();
        check("basic_fd_pulse", {31'd0, frame_done}, 32'd0);

        // Watermark hysteresis
        do_reset();
        lcd_en_i = 1'b1; frame_words_i = 16'd100;
        cyc();
        for (int l = 1; l <= 11; l++) begin fifo_level = 5'(l); cyc(); end
        check("hys_req_l11", {31'd0, dma_req_out}, 32'd1);
        fifo_level = 5'd12; cyc();
        check("hys_req_l12", {31'd0, dma_req_out}, 32'd0);
        cyc();
        for (int l = 11; l >= 5; l--) begin fifo_level = 5'(l); cyc(); end
        check("hys_req_l5", {31'd0, dma_req_out}, 32'd0);
        fifo_level = 5'd4; cyc();
        check("hys_req_l4", {31'd0, dma_req_out}, 32'd1);
        fifo_level = '0;

        // Short frame
        do_reset();
        lcd_en_i = 1'b1; frame_words_i = 16'd20;
        cyc();
        fifo_push = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        fifo_push = 1'b0;
        check("short_w13", {16'd0, words_left}, 32'd13);
        fp_pulse = 1'b1; cyc(); fp_pulse = 1'b0;
        check("short_err",   {31'd0, short_err},   32'd1);
        check("short_bload", {31'd0, base_load},   32'd1);
        check("short_w20",   {16'd0, words_left},  32'd20);
        check("short_fill",  {31'd0, dma_req_out}, 32'd1);

        // Overrun, then simultaneous events
        do_reset();
        lcd_en_i = 1'b1; frame_words_i = 16'd4;
        cyc();
        fifo_push = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        cyc();
        fifo_push = 1'b0;
        check("ovr_err", {31'd0, ovr_err},    32'd1);
        check("ovr_w0",  {16'd0, words_left}, 32'd0);
        frame_words_i = 16'd6; fp_pulse = 1'b1; fifo_push = 1'b1;
        cyc();
        fifo_push = 1'b0;
        check("sim_w6",    {16'd0, words_left}, 32'd6);
        check("sim_ovr",   {31'd0, ovr_err},    32'd1);
        check("sim_bload", {31'd0, base_load},  32'd1);
        lcd_en_i = 1'b0;
        cyc();
        fp_pulse = 1'b0;
        check("dis_bload", {31'd0, base_load},   32'd0);
        check("dis_req",   {31'd0, dma_req_out}, 32'd0);
        check("dis_w6",    {16'd0, words_left},  32'd6);

        // Reset mid-frame
        do_reset();
        lcd_en_i = 1'b1; frame_words_i = 16'd5;
        cyc();
        fifo_push = 1'b1; cyc(); cyc(); fifo_push = 1'b0;
        check("mid_w3",  {16'd0, words_left},  32'd3);
        check("mid_req", {31'd0, dma_req_out}, 32'd1);
        HRESET = 1'b1; cyc();
        check("mid_rst_req",   {31'd0, dma_req_out}, 32'd0);
        check("mid_rst_words", {16'd0, words_left},  32'd0);
        check("mid_rst_base",  frame_base_out,       32'd0);
        HRESET = 1'b0; lcd_en_i = 1'b0; cyc();
        check("mid_idle_req", {31'd0, dma_req_out}, 32'd0);
        lcd_en_i = 1'b1; cyc();
        check("mid_en_req", {31'd0, dma_req_out}, 32'd1);

        // Random traffic; FIFO level wanders so both watermarks get crossed
        lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            HRESET        = ($urandom_range(0, 299) == 0);
            lcd_en_i      = ($urandom_range(0, 24) != 0);
            fp_pulse      = ($urandom_range(0, 39) == 0);
            fifo_push     = ($urandom_range(0, 2) != 0);
            frame_words_i = WW'($urandom_range(0, 14));
            upbase_i      = $urandom & 32'hFFFF_FFFC;
            lvl           = lvl + $urandom_range(0, 2) - 1;
            if (lvl < 0) lvl = 0;
            if (lvl > 16) lvl = 16;
            fifo_level    = 5'(lvl);
            cyc();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
